// File: rtl/synapse_av_pkg.sv
// Shared types and status-word layout for the synapse316 MCU Avalon-MM bridge.
package synapse_av_pkg;

    localparam int AV_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } bridge_state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_CNT_LSB = 1;

    typedef struct packed {
        logic [2*AV_DATA_W-1:0] addr;
        logic [AV_DATA_W-1:0]   data;
    } wfifo_entry_t;

    // Sticky-flag positions follow the FIFO count field, whose width tracks the depth.
    function automatic int stat_ovf_bit(input int cnt_w);
        return STAT_CNT_LSB + cnt_w;
    endfunction

endpackage

// File: rtl/bridge_wfifo.sv
// Posted-write FIFO: synchronous push/pop, head visible combinationally, pointers flushed by reset.
module bridge_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mcu_avalon_bridge.sv
// Register-mapped Avalon-MM master for the synapse316 MCU with posted writes and address auto-increment.
// Optional waitrequest timeout/abort is compiled in when AVB_TIMEOUT_EN is defined.
module mcu_avalon_bridge
    import synapse_av_pkg::*;
#(
    parameter int DATA_W      = AV_DATA_W,
    parameter int WFIFO_DEPTH = 4,
    parameter int ADDR_INC    = 2
`ifdef AVB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                sysclk,
    input  logic                sysreset_n,
    input  logic [DATA_W-1:0]   r_load_data,
    input  logic                ld_ad_hi,
    input  logic                ld_ad_lo,
    input  logic                ld_wdata,
    input  logic                rd_wdata,
    input  logic                ld_ctrl,
    output logic [DATA_W-1:0]   ad_hi,
    output logic [DATA_W-1:0]   ad_lo,
    output logic [DATA_W-1:0]   read_data,
    output logic [DATA_W-1:0]   status,
    output logic                mcu_wait,
    output logic [2*DATA_W-1:0] av_address,
    output logic                av_read,
    output logic                av_write,
    output logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W-1:0]   av_readdata,
    input  logic                av_waitrequest
);

    localparam int ADDR_W   = 2*DATA_W;
    localparam int CNT_W    = $clog2(WFIFO_DEPTH) + 1;
    localparam int STAT_OVF = stat_ovf_bit(CNT_W);
    localparam int STAT_TOE = STAT_OVF + 1;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(ADDR_INC);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, rd_addr_q;
    logic [ADDR_W-1:0] addr_after_push, addr_after_rd;
    logic [DATA_W-1:0] rbuf_q, read_data_q, cap_val;
    logic              read_pending_q, auto_inc_q, overflow_q;
    logic              push_ok, rd_trig, clr_sticky;
    logic              fifo_pop, fifo_full, fifo_empty, rd_done, cap_load;
    logic              tmo_hit, timeout_err, busy;
    logic [CNT_W-1:0]  fifo_count;
    wfifo_entry_t      push_entry, head_entry;

    assign push_ok    = ld_wdata & ~fifo_full;
    assign rd_trig    = rd_wdata & ~read_pending_q;
    assign clr_sticky = ld_ctrl & r_load_data[1];
    assign push_entry = '{addr: addr_q, data: r_load_data};

    // A write and a read trigger in the same cycle each consume one increment, write first.
    assign addr_after_push = addr_q + ((push_ok & auto_inc_q) ? INC : '0);
    assign addr_after_rd   = addr_after_push + ((rd_trig & auto_inc_q) ? INC : '0);

    bridge_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .WIDTH ($bits(wfifo_entry_t))
    ) u_wfifo (
        .clk_i   (sysclk),
        .rst_ni  (sysreset_n),
        .push_i  (push_ok),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            rd_addr_q      <= '0;
            rbuf_q         <= '0;
            read_data_q    <= '0;
            read_pending_q <= 1'b0;
            auto_inc_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_ad_hi || ld_ad_lo) begin
                if (ld_ad_hi) addr_q[ADDR_W-1:DATA_W] <= r_load_data;
                if (ld_ad_lo) addr_q[DATA_W-1:0]      <= r_load_data;
            end else begin
                addr_q <= addr_after_rd;
            end
            if (rd_trig) begin
                read_pending_q <= 1'b1;
                rd_addr_q      <= addr_after_push;
            end else if (rd_done) begin
                read_pending_q <= 1'b0;
            end
            if (ld_ctrl)                  auto_inc_q  <= r_load_data[0];
            if (ld_wdata && fifo_full)    overflow_q  <= 1'b1;
            else if (clr_sticky)          overflow_q  <= 1'b0;
            if (cap_load)                 rbuf_q      <= cap_val;
            if (state_q == CAPTURE)       read_data_q <= rbuf_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        rd_done  = 1'b0;
        cap_load = 1'b0;
        cap_val  = av_readdata;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty)         state_d = WRITE;
                else if (read_pending_q) state_d = READ;
            end
            WRITE: begin
                if (!av_waitrequest || tmo_hit) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (!av_waitrequest || tmo_hit) begin
                    cap_load = 1'b1;
                    if (tmo_hit) cap_val = '1;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                rd_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AVB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_err_q;
    logic             stalled;

    assign stalled     = av_waitrequest & ((state_q == WRITE) | (state_q == READ));
    assign tmo_hit     = stalled & (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_err_q;

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (tmo_hit || !stalled) tmo_cnt_q <= '0;
            else                     tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (tmo_hit)             timeout_err_q <= 1'b1;
            else if (clr_sticky)     timeout_err_q <= 1'b0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy = (state_q != IDLE) | ~fifo_empty | read_pending_q;

    always_comb begin
        status                         = '0;
        status[STAT_BUSY]              = busy;
        status[STAT_CNT_LSB +: CNT_W]  = fifo_count;
        status[STAT_OVF]               = overflow_q;
        status[STAT_TOE]               = timeout_err;
    end

    assign ad_hi        = addr_q[ADDR_W-1:DATA_W];
    assign ad_lo        = addr_q[DATA_W-1:0];
    assign read_data    = read_data_q;
    assign mcu_wait     = fifo_full | read_pending_q | (state_q == READ) | (state_q == CAPTURE);
    assign av_write     = (state_q == WRITE);
    assign av_read      = (state_q == READ);
    assign av_address   = (state_q == WRITE) ? head_entry.addr : rd_addr_q;
    assign av_writedata = head_entry.data;

endmodule
